// File: rtl/bus_irq_ctrl_pkg.sv
// Shared bus field layout plus the interrupt controller's register map.
// Every block attached to the internal bus imports this package.
package bus_irq_ctrl_pkg;

   localparam int unsigned BUS_ADDR_W = 32;
   localparam int unsigned BUS_DATA_W = 32;

   typedef struct packed {
      logic [BUS_ADDR_W-1:0] addr;
      logic                  rd_req;
      logic                  wr_req;
      logic [BUS_DATA_W-1:0] wr_data;
   } bus_req_t;

   typedef struct packed {
      logic [BUS_DATA_W-1:0] rd_data;
      logic                  rd_ack;
      logic                  wr_ack;
      logic                  irq;
   } bus_rsp_t;

   localparam int unsigned BUS_IN_WIDTH  = $bits(bus_req_t);
   localparam int unsigned BUS_OUT_WIDTH = $bits(bus_rsp_t);

   // Interrupt controller register window: four words.
   localparam logic [3:0] IRQ_OFS_PENDING = 4'h0;
   localparam logic [3:0] IRQ_OFS_ENABLE  = 4'h4;
   localparam logic [3:0] IRQ_OFS_MODE    = 4'h8;
   localparam logic [3:0] IRQ_OFS_STATUS  = 4'hC;

   localparam int unsigned IRQ_STATUS_ANY_BIT = 31;
   localparam int unsigned IRQ_STATUS_IDX_LSB = 0;
   localparam int unsigned IRQ_IDX_W          = 5;

   typedef enum logic [1:0] {
      RegPending = IRQ_OFS_PENDING[3:2],
      RegEnable  = IRQ_OFS_ENABLE[3:2],
      RegMode    = IRQ_OFS_MODE[3:2],
      RegStatus  = IRQ_OFS_STATUS[3:2]
   } irq_reg_e;

   function automatic irq_reg_e irq_reg_sel(input logic [1:0] word);
      return irq_reg_e'(word);
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: index of the lowest-numbered set bit.
// idx is 0 and valid is low when no bit is set.
module irq_prio_enc
   import bus_irq_ctrl_pkg::*;
#(
   parameter int unsigned NIRQ = 32
) (
   input  logic [NIRQ-1:0]      vec,
   output logic [IRQ_IDX_W-1:0] idx,
   output logic                 valid
);

   // Scan downward so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = IRQ_IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_irq_ctrl.sv
// Bus-attached interrupt controller: per-source edge/level capture, enable mask,
// holdoff coalescing and a registered interrupt request to the CPU.
module bus_irq_ctrl
   import bus_irq_ctrl_pkg::*;
#(
   parameter logic [31:0] BUS_ADDR   = 32'h0,
   parameter int unsigned NIRQ       = 32,
   parameter logic [31:0] LEVEL_INIT = 32'h0,
   parameter int unsigned HOLDOFF    = 15
) (
   input  logic                     bus_clk,
   input  logic                     bus_reset,
   input  logic [BUS_IN_WIDTH-1:0]  bus_in,
   output logic [BUS_OUT_WIDTH-1:0] bus_out,
   input  logic [NIRQ-1:0]          trig,
   output logic                     irq
);

   bus_req_t req;
   bus_rsp_t rsp;
   irq_reg_e sel;
   logic     hit, rd_en, wr_en;

   logic [NIRQ-1:0] pending_q, pending_d;
   logic [NIRQ-1:0] enable_q, enable_d;
   logic [NIRQ-1:0] mode_q, mode_d;
   logic [NIRQ-1:0] trig_dly_q;
   logic            arm_q;
   logic [7:0]      count_q, count_d;
   logic            irq_q, irq_d;
   logic            rd_ack_q, wr_ack_q;
   logic [31:0]     rd_data_q, rd_data_d;

   logic [NIRQ-1:0]      edge_set, clr, active;
   logic [IRQ_IDX_W-1:0] prio_idx;
   logic                 prio_valid;
   logic [31:0]          status, rd_val;
   logic                 unused_bits;

   assign req   = bus_req_t'(bus_in);
   assign hit   = ({req.addr[31:4], 4'h0} == BUS_ADDR);
   assign sel   = irq_reg_sel(req.addr[3:2]);
   assign rd_en = hit & req.rd_req;
   assign wr_en = hit & req.wr_req;

   assign unused_bits = ^{req.addr[1:0], req.wr_data};

   assign active = pending_q & enable_q;

   irq_prio_enc #(
      .NIRQ(NIRQ)
   ) u_prio (
      .vec  (active),
      .idx  (prio_idx),
      .valid(prio_valid)
   );

   always_comb begin
      status = '0;
      status[IRQ_STATUS_ANY_BIT] = prio_valid;
      status[IRQ_STATUS_IDX_LSB +: IRQ_IDX_W] = prio_idx;
   end

   always_comb begin
      rd_val = '0;
      unique case (sel)
         RegPending: rd_val = 32'(pending_q);
         RegEnable:  rd_val = 32'(enable_q);
         RegMode:    rd_val = 32'(mode_q);
         RegStatus:  rd_val = status;
      endcase
   end

   always_comb begin
      // arm_q masks the first cycle after reset so a line already high is not an edge.
      edge_set = trig & ~trig_dly_q & ~mode_q & {NIRQ{arm_q}};

      clr = '0;
      if (wr_en && sel == RegPending) clr = req.wr_data[NIRQ-1:0];

      // Set beats clear; level bits ignore clear and just follow trig.
      pending_d = (mode_q & trig) | (~mode_q & ((pending_q & ~clr) | edge_set));

      enable_d = enable_q;
      if (wr_en && sel == RegEnable) enable_d = req.wr_data[NIRQ-1:0];

      mode_d = mode_q;
      if (wr_en && sel == RegMode) mode_d = req.wr_data[NIRQ-1:0];

      if (|(pending_d & ~pending_q)) begin
         count_d = 8'(HOLDOFF);
      end else if (count_q != 8'd0) begin
         count_d = count_q - 8'd1;
      end else begin
         count_d = 8'd0;
      end

      // Rising needs the settled pending/enable; the next-state term lets a
      // clear or disable drop irq on the cycle right after the write.
      irq_d = (count_q == 8'd0) && (|active) && (|(pending_d & enable_d));

      rd_data_d = rd_en ? rd_val : '0;
   end

   always_ff @(posedge bus_clk) begin
      if (bus_reset) begin
         pending_q  <= '0;
         enable_q   <= '0;
         mode_q     <= LEVEL_INIT[NIRQ-1:0];
         trig_dly_q <= '0;
         arm_q      <= 1'b0;
         count_q    <= 8'd0;
         irq_q      <= 1'b0;
         rd_ack_q   <= 1'b0;
         wr_ack_q   <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         pending_q  <= pending_d;
         enable_q   <= enable_d;
         mode_q     <= mode_d;
         trig_dly_q <= trig;
         arm_q      <= 1'b1;
         count_q    <= count_d;
         irq_q      <= irq_d;
         rd_ack_q   <= rd_en;
         wr_ack_q   <= wr_en;
         rd_data_q  <= rd_data_d;
      end
   end

   always_comb begin
      rsp         = '0;
      rsp.rd_data = rd_data_q;
      rsp.rd_ack  = rd_ack_q;
      rsp.wr_ack  = wr_ack_q;
      rsp.irq     = irq_q;
   end

   assign bus_out = rsp;
   assign irq     = irq_q;

endmodule

// File: tb/tb_bus_irq_ctrl.sv
// Directed bench for bus_irq_ctrl: two instances (HOLDOFF 0 and 15), NIRQ = 8.
module tb_bus_irq_ctrl;
   import bus_irq_ctrl_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_1230;

   logic clk;
   logic rst;

   bus_req_t                 req_a, req_b;
   bus_rsp_t                 rsp_a, rsp_b;
   logic [BUS_IN_WIDTH-1:0]  bus_in_a, bus_in_b;
   logic [BUS_OUT_WIDTH-1:0] bus_out_a, bus_out_b;
   logic [7:0]               trig_a, trig_b;
   logic                     irq_a, irq_b;

   int n_vec = 0;
   int n_err = 0;

   assign bus_in_a = req_a;
   assign bus_in_b = req_b;
   assign rsp_a    = bus_rsp_t'(bus_out_a);
   assign rsp_b    = bus_rsp_t'(bus_out_b);

   bus_irq_ctrl #(
      .BUS_ADDR  (BASE),
      .NIRQ      (8),
      .LEVEL_INIT(32'h0),
      .HOLDOFF   (0)
   ) dut_a (
      .bus_clk  (clk),
      .bus_reset(rst),
      .bus_in   (bus_in_a),
      .bus_out  (bus_out_a),
      .trig     (trig_a),
      .irq      (irq_a)
   );

   bus_irq_ctrl #(
      .BUS_ADDR  (BASE),
      .NIRQ      (8),
      .LEVEL_INIT(32'h0),
      .HOLDOFF   (15)
   ) dut_b (
      .bus_clk  (clk),
      .bus_reset(rst),
      .bus_in   (bus_in_b),
      .bus_out  (bus_out_b),
      .trig     (trig_b),
      .irq      (irq_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_a(input logic [3:0] ofs, output logic [31:0] data, output logic ack);
      req_a.addr   = BASE | {28'h0, ofs};
      req_a.rd_req = 1'b1;
      tick();
      data = rsp_a.rd_data;
      ack  = rsp_a.rd_ack;
      req_a.rd_req = 1'b0;
   endtask

   task automatic wr_a(input logic [3:0] ofs, input logic [31:0] data, output logic ack);
      req_a.addr    = BASE | {28'h0, ofs};
      req_a.wr_data = data;
      req_a.wr_req  = 1'b1;
      tick();
      ack = rsp_a.wr_ack;
      req_a.wr_req = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic        a;
      rst = 1'b1;
      req_a = '0;
      req_b = '0;
      trig_a = '0;
      trig_b = '0;
      repeat (3) tick();
      n_vec++;
      if (bus_out_a !== '0) begin
         n_err++;
         $display("FAIL reset_bus_out: got %h want 0", bus_out_a);
      end
      n_vec++;
      if (irq_a !== 1'b0 || irq_b !== 1'b0) begin
         n_err++;
         $display("FAIL reset_irq: got %b%b want 00", irq_a, irq_b);
      end
      rst = 1'b0;
      rd_a(4'h0, d, a);
      n_vec++;
      if (a !== 1'b1 || d !== 32'h0) begin
         n_err++;
         $display("FAIL reset_pending: got ack=%b %h want ack=1 0", a, d);
      end
      rd_a(4'h4, d, a);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++;
         $display("FAIL reset_enable: got %h want 0", d);
      end
      rd_a(4'h8, d, a);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++;
         $display("FAIL reset_mode: got %h want 0", d);
      end
      rd_a(4'hC, d, a);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++;
         $display("FAIL reset_status: got %h want 0", d);
      end
      // Outside the window: no ack, no data.
      req_a.addr   = BASE + 32'h10;
      req_a.rd_req = 1'b1;
      tick();
      n_vec++;
      if (rsp_a.rd_ack !== 1'b0 || rsp_a.rd_data !== 32'h0) begin
         n_err++;
         $display("FAIL decode_miss: got ack=%b %h want ack=0 0", rsp_a.rd_ack, rsp_a.rd_data);
      end
      req_a.rd_req = 1'b0;
   endtask

   task automatic test_edge_irq();
      logic [31:0] d;
      logic        a;
      wr_a(4'h4, 32'h01, a);
      n_vec++;
      if (a !== 1'b1) begin
         n_err++;
         $display("FAIL wr_ack: got %b want 1", a);
      end
      trig_a = 8'h01;
      tick();
      trig_a = 8'h00;
      n_vec++;
      if (irq_a !== 1'b0) begin
         n_err++;
         $display("FAIL irq_early: got %b want 0", irq_a);
      end
      tick();
      n_vec++;
      if (irq_a !== 1'b1 || rsp_a.irq !== 1'b1) begin
         n_err++;
         $display("FAIL irq_latency2: got port=%b field=%b want 1 1", irq_a, rsp_a.irq);
      end
      rd_a(4'h0, d, a);
      n_vec++;
      if (d !== 32'h01) begin
         n_err++;
         $display("FAIL edge_pending: got %h want 01", d);
      end
      rd_a(4'hC, d, a);
      n_vec++;
      if (d !== 32'h8000_0000) begin
         n_err++;
         $display("FAIL status_bit0: got %h want 80000000", d);
      end
      wr_a(4'h0, 32'h01, a);
      n_vec++;
      if (irq_a !== 1'b0 || rsp_a.irq !== 1'b0) begin
         n_err++;
         $display("FAIL irq_clear: got port=%b field=%b want 0 0", irq_a, rsp_a.irq);
      end
   endtask

   task automatic test_w1c_collision();
      logic [31:0] d;
      logic        a;
      trig_a = 8'h02;
      tick();
      trig_a = 8'h00;
      rd_a(4'h0, d, a);
      n_vec++;
      if (d !== 32'h02) begin
         n_err++;
         $display("FAIL bit1_set: got %h want 02", d);
      end
      req_a.addr    = BASE;
      req_a.wr_data = 32'h02;
      req_a.wr_req  = 1'b1;
      trig_a        = 8'h02;
      tick();
      req_a.wr_req = 1'b0;
      trig_a       = 8'h00;
      rd_a(4'h0, d, a);
      n_vec++;
      if (d !== 32'h02) begin
         n_err++;
         $display("FAIL set_beats_clear: got %h want 02", d);
      end
      n_vec++;
      if (irq_a !== 1'b0) begin
         n_err++;
         $display("FAIL masked_irq: got %b want 0", irq_a);
      end
      wr_a(4'h0, 32'h02, a);
      rd_a(4'h0, d, a);
      n_vec++;
      if (d !== 32'h00) begin
         n_err++;
         $display("FAIL w1c_plain: got %h want 00", d);
      end
   endtask

   task automatic test_level();
      logic [31:0] d, exp;
      logic        a;
      wr_a(4'h8, 32'h10, a);
      // Back-to-back reads each cycle; pending[4] lags trig[4] by one cycle.
      for (int k = 0; k < 12; k++) begin
         trig_a[4]     = (k < 10);
         req_a.addr    = BASE;
         req_a.rd_req  = 1'b1;
         req_a.wr_req  = (k == 5);
         req_a.wr_data = 32'h10;
         exp = (k >= 1 && k <= 10) ? 32'h10 : 32'h0;
         tick();
         n_vec++;
         if (rsp_a.rd_ack !== 1'b1 || rsp_a.rd_data !== exp) begin
            n_err++;
            $display("FAIL level_track[%0d]: got ack=%b %h want ack=1 %h",
                     k, rsp_a.rd_ack, rsp_a.rd_data, exp);
         end
         if (k == 5) begin
            n_vec++;
            if (rsp_a.wr_ack !== 1'b1) begin
               n_err++;
               $display("FAIL level_wr_ack: got %b want 1", rsp_a.wr_ack);
            end
         end
      end
      req_a.rd_req = 1'b0;
      req_a.wr_req = 1'b0;
      // Level -> edge while high: bit is retained, no new edge.
      trig_a[4] = 1'b1;
      tick();
      tick();
      wr_a(4'h8, 32'h00, a);
      trig_a[4] = 1'b0;
      rd_a(4'h0, d, a);
      rd_a(4'h0, d, a);
      n_vec++;
      if (d !== 32'h10) begin
         n_err++;
         $display("FAIL mode_retain: got %h want 10", d);
      end
      wr_a(4'h0, 32'h10, a);
      rd_a(4'h0, d, a);
      n_vec++;
      if (d !== 32'h00) begin
         n_err++;
         $display("FAIL retain_clear: got %h want 00", d);
      end
   endtask

   task automatic test_status();
      logic [31:0] d;
      logic        a;
      trig_a = 8'h28;
      tick();
      trig_a = 8'h00;
      wr_a(4'h4, 32'h20, a);
      rd_a(4'hC, d, a);
      n_vec++;
      if (d !== 32'h8000_0005) begin
         n_err++;
         $display("FAIL status_idx5: got %h want 80000005", d);
      end
      n_vec++;
      if (irq_a !== 1'b1) begin
         n_err++;
         $display("FAIL status_irq: got %b want 1", irq_a);
      end
      wr_a(4'h4, 32'h28, a);
      rd_a(4'hC, d, a);
      n_vec++;
      if (d !== 32'h8000_0003) begin
         n_err++;
         $display("FAIL status_lowest: got %h want 80000003", d);
      end
      wr_a(4'h4, 32'h00, a);
      n_vec++;
      if (irq_a !== 1'b0) begin
         n_err++;
         $display("FAIL disable_irq: got %b want 0", irq_a);
      end
      rd_a(4'hC, d, a);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++;
         $display("FAIL status_none: got %h want 00000000", d);
      end
      wr_a(4'h4, 32'hFFFF_FFFF, a);
      rd_a(4'h4, d, a);
      n_vec++;
      if (d !== 32'h0000_00FF) begin
         n_err++;
         $display("FAIL enable_width: got %h want 000000ff", d);
      end
      wr_a(4'hC, 32'hFFFF_FFFF, a);
      n_vec++;
      if (a !== 1'b1) begin
         n_err++;
         $display("FAIL status_wr_ack: got %b want 1", a);
      end
      rd_a(4'hC, d, a);
      n_vec++;
      if (d !== 32'h8000_0003) begin
         n_err++;
         $display("FAIL status_ro: got %h want 80000003", d);
      end
      wr_a(4'h4, 32'h00, a);
      wr_a(4'h0, 32'h28, a);
      rd_a(4'h0, d, a);
      n_vec++;
      if (d !== 32'h00) begin
         n_err++;
         $display("FAIL status_cleanup: got %h want 00", d);
      end
   endtask

   task automatic test_holdoff();
      logic exp;
      req_b.addr    = BASE + 32'h4;
      req_b.wr_data = 32'h0C;
      req_b.wr_req  = 1'b1;
      tick();
      req_b.wr_req = 1'b0;
      n_vec++;
      if (rsp_b.wr_ack !== 1'b1) begin
         n_err++;
         $display("FAIL holdoff_wr_ack: got %b want 1", rsp_b.wr_ack);
      end
      // Edge on bit 2 at cycle 0, bit 3 at cycle 5: irq expected from cycle 22.
      for (int k = 0; k < 25; k++) begin
         trig_b = (k == 0) ? 8'h04 : (k == 5) ? 8'h08 : 8'h00;
         exp = (k + 1 >= 22);
         tick();
         n_vec++;
         if (irq_b !== exp) begin
            n_err++;
            $display("FAIL holdoff_irq[cycle %0d]: got %b want %b", k + 1, irq_b, exp);
         end
      end
      trig_b = 8'h00;
   endtask

   task automatic test_reset_midop();
      logic [31:0] d;
      logic        a;
      wr_a(4'h4, 32'hFF, a);
      wr_a(4'h8, 32'h10, a);
      trig_a       = 8'hFF;
      req_a.addr   = BASE;
      req_a.rd_req = 1'b1;
      rst          = 1'b1;
      tick();
      n_vec++;
      if (rsp_a.rd_ack !== 1'b0 || bus_out_a !== '0) begin
         n_err++;
         $display("FAIL midop_no_ack: got %h want 0", bus_out_a);
      end
      tick();
      n_vec++;
      if (bus_out_a !== '0 || irq_a !== 1'b0) begin
         n_err++;
         $display("FAIL midop_held: got %h irq=%b want 0 0", bus_out_a, irq_a);
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rd_a(4'h0, d, a);
         n_vec++;
         if (a !== 1'b1 || d !== 32'h0) begin
            n_err++;
            $display("FAIL post_reset_pending[%0d]: got ack=%b %h want ack=1 0", k, a, d);
         end
      end
      rd_a(4'h8, d, a);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++;
         $display("FAIL post_reset_mode: got %h want 0", d);
      end
      rd_a(4'h4, d, a);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++;
         $display("FAIL post_reset_enable: got %h want 0", d);
      end
      n_vec++;
      if (irq_a !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_irq: got %b want 0", irq_a);
      end
      trig_a = 8'h00;
   endtask

   initial begin
      test_reset();
      test_edge_irq();
      test_w1c_collision();
      test_level();
      test_status();
      test_holdoff();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
